mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; only 32 is required to work.
REQ-002 SHALL have port Clk, input, 1; the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port Start, input, 1; request strobe, sampled only while Busy=0.
REQ-005 SHALL have port Op, input, 3; 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
REQ-006 SHALL have port A, input, 32; rs operand (dividend or multiplicand; source for MTHI/MTLO).
REQ-007 SHALL have port B, input, 32; rt operand (divisor or multiplier).
REQ-008 SHALL have port Busy, output, 1; high while an accepted operation is in progress.
REQ-009 SHALL have port Done, output, 1; one-cycle completion pulse.
REQ-010 SHALL have port DivByZero, output, 1; qualifies Done for a DIV/DIVU with B=0.
REQ-011 SHALL have ports Hi and Lo, output, 32 each; the architectural HI/LO registers.

Function
REQ-012 SHALL accept a request on a rising edge where Start=1 and Busy=0, latching Op, A and B; Start while Busy=1 SHALL be ignored with no side effects.
REQ-013 SHALL implement FSM states IDLE, CALC, FIX and DONE: IDLE->CALC on a multiply/divide accept; CALC->FIX after exactly 32 iterations; FIX->DONE; DONE->IDLE.
REQ-014 SHALL send MTHI/MTLO and divide-by-zero requests IDLE->DONE directly; Done SHALL pulse in the first cycle after acceptance.
REQ-015 SHALL assert Done in the 34th cycle after the acceptance edge for MULT/MULTU/DIV/DIVU/MADD/MSUB: 32 CALC cycles plus 1 FIX cycle.
REQ-016 SHALL drive Busy=1 in CALC and FIX and Busy=0 in IDLE and DONE, so a new Start is accepted in the Done cycle.
REQ-017 SHALL implement multiply as iterative shift-add on operand magnitudes, 1 bit per cycle, producing a 64-bit product {Hi,Lo}.
REQ-018 SHALL implement divide as iterative restoring division on magnitudes, 1 bit per cycle: Lo=quotient, Hi=remainder.
REQ-019 SHALL apply sign correction in FIX for signed ops: product sign = A[31]^B[31]; quotient sign = A[31]^B[31]; remainder sign = A[31] (truncating division).
REQ-020 SHALL, for signed DIV of 0x80000000 by 0xFFFFFFFF, produce Lo=0x80000000 and Hi=0 (two's-complement wrap).
REQ-021 SHALL, for MADD/MSUB, compute the signed 64-bit product and then set {Hi,Lo} = {Hi,Lo} +/- product modulo 2^64, using the HI/LO value held at acceptance.
REQ-022 SHALL, for DIV/DIVU with B=0, leave Hi/Lo unchanged and assert DivByZero together with Done for one cycle.
REQ-023 SHALL update Hi/Lo only on entry to DONE; they SHALL hold their values at all other times, including throughout CALC.
REQ-024 SHALL, for MTHI, write Hi=A; for MTLO, write Lo=A; the other register SHALL be unchanged.

Reset
REQ-025 SHALL, on Rst=0, immediately force state IDLE, Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0 and iteration counter=0.
REQ-026 SHALL, on reset during CALC/FIX, discard the operation with no Done pulse; the first Start after Rst returns high SHALL be accepted normally.

Structure
REQ-027 SHALL place Op encodings (OP_MULT..OP_MTLO) and state encodings in shared package mips_pkg.
REQ-028 SHALL hold all datapath state in a single module; the only sub-module SHALL be abs32 (two's-complement magnitude, instantiated for A and B).

Verification
REQ-029 SHALL verify: MULT A=0xFFFFFFFD (-3), B=5 -> Done at cycle 34, Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
REQ-030 SHALL verify: MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-031 SHALL verify: DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; then DIVU A=100, B=7 -> Lo=14, Hi=2.
REQ-032 SHALL verify: MTHI A=0, MTLO A=0x10, then MADD A=2, B=3 -> Hi=0, Lo=0x16; then MSUB A=2, B=3 -> Lo=0x10.
REQ-033 SHALL verify: DIV with B=0 -> Done and DivByZero high for one cycle after acceptance, and Hi/Lo unchanged.
REQ-034 SHALL verify: Start pulsed mid-CALC is ignored; Rst=0 at CALC cycle 10 -> Busy=0 and Hi=Lo=0 immediately, with no Done pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the HI/LO multiply-divide unit.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // One operand bit is consumed per CALC cycle.
  localparam int ITERS = 32;

  // Ops that work on magnitudes and need a sign fix-up afterwards.
  function automatic logic op_signed(op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/abs32.sv
// Two's-complement magnitude; passes the value through for unsigned ops.
module abs32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         sgn,
  output logic [W-1:0] mag
);

  assign mag = (sgn && a[W-1]) ? -a : a;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: 1 bit per cycle on magnitudes,
// sign fix-up in FIX, HI/LO written only on entry to DONE.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_e             state_q, state_d;
  op_e                op_q, op_in;
  logic [WIDTH-1:0]   ph, pl, dv;
  logic               neg_q, rneg_q, dbz_q;
  logic [4:0]         cnt;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sgn_in, div_in, short_in, accept;
  logic [WIDTH:0]     sum, shifted;
  logic [WIDTH-1:0]   diff, ph_nx, pl_nx;
  logic [2*WIDTH-1:0] prod, sprod, res;

  assign op_in    = op_e'(Op);
  assign sgn_in   = op_signed(op_in);
  assign div_in   = op_in inside {OP_DIV, OP_DIVU};
  assign short_in = (op_in inside {OP_MTHI, OP_MTLO}) || (div_in && (B == '0));
  assign accept   = Start && !Busy;

  assign Busy      = (state_q == CALC) || (state_q == FIX);
  assign Done      = (state_q == DONE);
  assign DivByZero = Done && dbz_q;

  abs32 #(.W(WIDTH)) u_abs_a (.a(A), .sgn(sgn_in), .mag(mag_a));
  abs32 #(.W(WIDTH)) u_abs_b (.a(B), .sgn(sgn_in), .mag(mag_b));

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: moves and divide-by-zero skip straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) state_d = short_in ? DONE : CALC;
      end
      CALC:    if (cnt == 5'(ITERS - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  // {ph,pl} holds partial product / {remainder,quotient}; dv is the
  // multiplicand or divisor magnitude.
  always_comb begin
    sum     = {1'b0, ph} + (pl[0] ? {1'b0, dv} : '0);
    shifted = {ph, pl[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - dv;
    ph_nx   = sum[WIDTH:1];
    pl_nx   = {sum[0], pl[WIDTH-1:1]};
    if (op_q inside {OP_DIV, OP_DIVU}) begin
      if (shifted >= {1'b0, dv}) begin
        ph_nx = diff;
        pl_nx = {pl[WIDTH-2:0], 1'b1};
      end else begin
        ph_nx = shifted[WIDTH-1:0];
        pl_nx = {pl[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up and accumulate; HI/LO are stable until DONE so MADD/MSUB
  // see the value that was there at acceptance.
  always_comb begin
    prod  = {ph, pl};
    sprod = neg_q ? -prod : prod;
    res   = sprod;
    case (op_q)
      OP_MADD:         res = {Hi, Lo} + sprod;
      OP_MSUB:         res = {Hi, Lo} - sprod;
      OP_DIV, OP_DIVU: res = {(rneg_q ? -ph : ph), (neg_q ? -pl : pl)};
      default:         res = sprod;
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, commit in FIX.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      op_q   <= OP_MULT;
      ph     <= '0;
      pl     <= '0;
      dv     <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dbz_q  <= 1'b0;
      cnt    <= '0;
      Hi     <= '0;
      Lo     <= '0;
    end else if (accept) begin
      op_q   <= op_in;
      cnt    <= '0;
      ph     <= '0;
      pl     <= div_in ? mag_a : mag_b;
      dv     <= div_in ? mag_b : mag_a;
      neg_q  <= sgn_in && (A[WIDTH-1] ^ B[WIDTH-1]);
      rneg_q <= sgn_in && A[WIDTH-1];
      dbz_q  <= div_in && (B == '0);
      if (op_in == OP_MTHI) Hi <= A;
      if (op_in == OP_MTLO) Lo <= A;
    end else if (state_q == CALC) begin
      ph  <= ph_nx;
      pl  <= pl_nx;
      cnt <= cnt + 5'd1;
    end else if (state_q == FIX) begin
      Hi <= res[2*WIDTH-1:WIDTH];
      Lo <= res[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases with literal results plus random
// traffic, all checked each cycle against an arithmetic model of HI/LO.
module tb_mul_div_unit;

  logic        Clk, Rst, Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state
  logic [31:0] m_hi = 0, m_lo = 0, pend_hi = 0, pend_lo = 0;
  int          m_left = 0;
  bit          m_done = 0, m_dbz = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s act=%h exp=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one request, from plain 64-bit arithmetic.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, b, hi, lo,
                                 output logic [31:0] nh, nl, output bit dbz, output bit quick);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    nh = hi; nl = lo; dbz = 0; quick = 0;
    p = 0; q = 0; r = 0;
    case (op)
      3'd0: begin p = sa * sb; {nh, nl} = p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; {nh, nl} = p; end
      3'd2: if (b == 0) begin dbz = 1; quick = 1; end
            else begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      3'd3: if (b == 0) begin dbz = 1; quick = 1; end
            else begin nl = a / b; nh = a % b; end
      3'd4: begin p = {hi, lo} + sa * sb; {nh, nl} = p; end
      3'd5: begin p = {hi, lo} - sa * sb; {nh, nl} = p; end
      3'd6: begin nh = a; quick = 1; end
      default: begin nl = a; quick = 1; end
    endcase
  endfunction

  // Per-cycle compare against the model, then advance the model across the
  // coming rising edge using the inputs that edge will sample.
  initial begin
    logic [31:0] nh, nl;
    bit dbz, quick;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        m_hi = 0; m_lo = 0; m_left = 0; m_done = 0; m_dbz = 0;
      end
      chk("busy", 64'(Busy), 64'(m_left > 0));
      chk("done", 64'(Done), 64'(m_done));
      chk("dbz",  64'(DivByZero), 64'(m_dbz));
      chk("hi",   64'(Hi), 64'(m_hi));
      chk("lo",   64'(Lo), 64'(m_lo));
      if (Rst) begin
        m_dbz = 0;
        if (m_left > 0) begin
          m_done = 0;
          m_left--;
          if (m_left == 0) begin
            m_done = 1; m_hi = pend_hi; m_lo = pend_lo;
          end
        end else begin
          m_done = 0;
          if (Start) begin
            ref_op(Op, A, B, m_hi, m_lo, nh, nl, dbz, quick);
            if (quick) begin
              m_done = 1; m_dbz = dbz; m_hi = nh; m_lo = nl;
            end else begin
              m_left = 33; pend_hi = nh; pend_lo = nl;
            end
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, output int acc);
    Start = 1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    acc = cyc;
    Start = 0;
  endtask

  task automatic wait_done(input int acc, input int exp_lat);
    int n = 0;
    while (!Done && n < 80) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!Done) begin
      total++; bad++;
      $display("FAIL timeout waiting for Done (acc cycle %0d)", acc);
    end else chk("latency", 64'(cyc - acc + 1), 64'(exp_lat));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc;
    Rst = 0; Start = 0; Op = 0; A = 0; B = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    Rst = 1;
    @(posedge Clk); #1;

    issue(3'd0, 32'hFFFF_FFFD, 32'd5, acc);          // MULT -3*5
    wait_done(acc, 34);
    chk("mult", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    @(posedge Clk); #1;
    chk("done_pulse", 64'(Done), 64'd0);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);  // MULTU
    wait_done(acc, 34);
    chk("multu", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2, acc);           // DIV -7/2, back-to-back
    wait_done(acc, 34);
    chk("div", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd3, 32'd100, 32'd7, acc);                  // DIVU
    wait_done(acc, 34);
    chk("divu", {Hi, Lo}, {32'd2, 32'd14});
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, acc);   // DIV overflow wrap
    wait_done(acc, 34);
    chk("div_wrap", {Hi, Lo}, 64'h0000_0000_8000_0000);

    issue(3'd6, 32'd0, 32'd0, acc);                    // MTHI
    wait_done(acc, 1);
    issue(3'd7, 32'h10, 32'd0, acc);                   // MTLO
    wait_done(acc, 1);
    chk("mtlo", {Hi, Lo}, 64'h10);
    issue(3'd4, 32'd2, 32'd3, acc);                    // MADD
    wait_done(acc, 34);
    chk("madd", {Hi, Lo}, 64'h16);
    issue(3'd5, 32'd2, 32'd3, acc);                    // MSUB
    wait_done(acc, 34);
    chk("msub", {Hi, Lo}, 64'h10);

    issue(3'd2, 32'd55, 32'd0, acc);                   // DIV by zero
    wait_done(acc, 1);
    chk("dbz_flag", 64'(DivByZero), 64'd1);
    chk("dbz_hilo", {Hi, Lo}, 64'h10);
    @(posedge Clk); #1;
    chk("dbz_clear", 64'(DivByZero), 64'd0);

    issue(3'd0, 32'd7, 32'd6, acc);                    // Start mid-CALC ignored
    repeat (5) @(posedge Clk);
    #1;
    Start = 1; Op = 3'd6; A = 32'hDEAD; B = 0;
    @(posedge Clk); #1;
    Start = 0;
    wait_done(acc, 34);
    chk("ignored", {Hi, Lo}, 64'd42);

    issue(3'd0, 32'd9, 32'd9, acc);                    // reset at CALC cycle 10
    repeat (9) @(posedge Clk);
    #1;
    Rst = 0;
    #1;
    chk("rst_mid_busy", 64'(Busy), 64'd0);
    chk("rst_mid_hilo", {Hi, Lo}, 64'd0);
    repeat (3) begin
      @(posedge Clk); #1;
      chk("rst_no_done", 64'(Done), 64'd0);
    end
    Rst = 1;
    @(posedge Clk); #1;
    issue(3'd1, 32'd3, 32'd4, acc);
    wait_done(acc, 34);
    chk("after_rst", {Hi, Lo}, 64'd12);

    // random traffic, including requests while busy
    for (int i = 0; i < 4000; i++) begin
      Start = ($urandom_range(0, 3) == 0);
      Op = 3'($urandom_range(0, 7));
      A = pick();
      B = pick();
      @(posedge Clk); #1;
    end
    Start = 0;
    repeat (40) @(posedge Clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
